// File: rtl/alu_share_if.sv
// Request/response bundle between two ALU requesters and the shared ALU stage.
// master drives the requests and rsp_ready; slave is the arbiter.
interface alu_share_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [XLEN-1:0]  req0_a;
  logic [XLEN-1:0]  req0_b;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [XLEN-1:0]  req1_a;
  logic [XLEN-1:0]  req1_b;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_port;
  logic [TAG_W-1:0] rsp_tag;
  logic [XLEN-1:0]  rsp_data;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_port, rsp_tag, rsp_data, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_port, rsp_tag, rsp_data, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU stage between the integer datapath
// (port 0) and the capability unit (port 1). Define ALU_SHARE_PERF_EN for perf counters.
//
// state | meaning
// EMPTY | result register holds nothing
// FULL  | result register holds an undelivered result
module alu_share_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_share_if.slave  bus
`ifdef ALU_SHARE_PERF_EN
  ,
  output logic [31:0] perf_grant0,
  output logic [31:0] perf_grant1,
  output logic [31:0] perf_conflict
`endif
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic             can_accept;
  logic             grant_valid;
  logic             grant_port;
  logic             accept;

  logic [3:0]       sel_op;
  logic [XLEN-1:0]  sel_a, sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic [XLEN-1:0]  alu_data;
  logic             alu_err;

  logic             rsp_port_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [XLEN-1:0]  rsp_data_q;
  logic             rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant_port  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_port = ~last_grant_q;
    else if (bus.req1_valid)              grant_port = 1'b1;

    can_accept = (state_q == EMPTY) | ((state_q == FULL) & bus.rsp_ready);
    accept     = can_accept & grant_valid;

    state_d = state_q;
    if (accept)                               state_d = FULL;
    else if (state_q == FULL && bus.rsp_ready) state_d = EMPTY;
  end

  always_comb begin
    sel_op  = grant_port ? bus.req1_op  : bus.req0_op;
    sel_a   = grant_port ? bus.req1_a   : bus.req0_a;
    sel_b   = grant_port ? bus.req1_b   : bus.req0_b;
    sel_tag = grant_port ? bus.req1_tag : bus.req0_tag;

    alu_data = '0;
    alu_err  = 1'b0;
    case (sel_op)
      4'b0000: alu_data = sel_a + sel_b;
      4'b0001: alu_data = sel_a - sel_b;
      4'b0010: alu_data = sel_a & sel_b;
      4'b0011: alu_data = sel_a | sel_b;
      4'b0100: alu_data = sel_a ^ sel_b;
      default: alu_err  = 1'b1;
    endcase
  end

  // Data fields keep their last value when the result drains without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rsp_port_q   <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else if (accept) begin
      last_grant_q <= grant_port;
      rsp_port_q   <= grant_port;
      rsp_tag_q    <= sel_tag;
      rsp_data_q   <= alu_data;
      rsp_err_q    <= alu_err;
    end
  end

  assign bus.req0_ready = accept & ~grant_port;
  assign bus.req1_ready = accept &  grant_port;
  assign bus.rsp_valid  = (state_q == FULL);
  assign bus.rsp_port   = rsp_port_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

`ifdef ALU_SHARE_PERF_EN
  // With only one grant per cycle, both valids high always means one port lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (accept && !grant_port && perf_grant0 != 32'hFFFF_FFFF)
        perf_grant0 <= perf_grant0 + 32'd1;
      if (accept && grant_port && perf_grant1 != 32'hFFFF_FFFF)
        perf_grant1 <= perf_grant1 + 32'd1;
      if (bus.req0_valid && bus.req1_valid && !(bus.req0_ready && bus.req1_ready)
          && perf_conflict != 32'hFFFF_FFFF)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_alu_share_arbiter;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_share_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

`ifdef ALU_SHARE_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_SHARE_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  // Reference model: what the consumer should see, and who has priority next.
  bit               m_full;
  bit               m_last;
  bit               m_port;
  logic [TAG_W-1:0] m_tag;
  logic [XLEN-1:0]  m_data;
  bit               m_err;
  int unsigned      m_g0, m_g1, m_conf;

  function automatic logic [XLEN:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    // bit XLEN is the error flag
    longint unsigned ua = a, ub = b, mod = 64'd1 << XLEN;
    case (op)
      4'd0: return {1'b0, XLEN'((ua + ub) % mod)};
      4'd1: return {1'b0, XLEN'((ua + mod - ub) % mod)};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      default: return {1'b1, {XLEN{1'b0}}};
    endcase
  endfunction

  // Which port the model expects to win this cycle (-1: nobody).
  function automatic int exp_winner();
    bit v0 = bus.req0_valid, v1 = bus.req1_valid;
    if (m_full && !bus.rsp_ready) return -1;
    if (v0 && v1) return m_last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0; m_last = 1; m_port = 0; m_tag = '0; m_data = '0; m_err = 0;
    m_g0 = 0; m_g1 = 0; m_conf = 0;
  endtask

  // Advance the model with the inputs currently applied, then cross one rising edge.
  task automatic tick();
    int w = exp_winner();
    logic [XLEN:0] r;
    if (bus.req0_valid && bus.req1_valid) m_conf++;
    if (w == 0) begin
      r = ref_alu(bus.req0_op, bus.req0_a, bus.req0_b);
      m_tag = bus.req0_tag; m_g0++;
    end else if (w == 1) begin
      r = ref_alu(bus.req1_op, bus.req1_a, bus.req1_b);
      m_tag = bus.req1_tag; m_g1++;
    end
    if (w >= 0) begin
      m_full = 1; m_port = w[0]; m_last = w[0]; m_data = r[XLEN-1:0]; m_err = r[XLEN];
    end else if (m_full && bus.rsp_ready) begin
      m_full = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int p, input bit v, input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
    end
  endtask

  function automatic logic [3:0] rand_op();
    int r = $urandom_range(0, 7);
    return (r < 5) ? 4'(r) : 4'($urandom_range(5, 15));
  endfunction

  task automatic set_rand_req(input int p);
    set_req(p, 1'b1, rand_op(), $urandom(), $urandom(), 4'($urandom_range(0, 15)));
  endtask

  task automatic drain();
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
    tick(); tick();
  endtask

  task automatic test_reset();
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
    set_req(0, 0, '0, '0, '0, '0); set_req(1, 0, '0, '0, '0, '0);
    rst_n = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_port !== 1'b0) begin failures++; $display("FAIL reset_rsp_port got=%0b exp=0", bus.rsp_port); end
    checks++; if (bus.rsp_tag !== '0) begin failures++; $display("FAIL reset_rsp_tag got=%0h exp=0", bus.rsp_tag); end
    checks++; if (bus.rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%0h exp=0", bus.rsp_data); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%0b exp=0", bus.rsp_err); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_readies got=%b exp=00", {bus.req0_ready, bus.req1_ready}); end
`ifdef ALU_SHARE_PERF_EN
    checks++; if ({perf_grant0, perf_grant1, perf_conflict} !== 96'd0) begin failures++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_grant0, perf_grant1, perf_conflict); end
`endif
    rst_n = 1;
  endtask

  task automatic test_basic_add();
    bus.rsp_ready = 1;
    set_req(0, 1, 4'b0000, 32'd5, 32'd7, 4'd3);
    @(negedge clk);
    checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL add_req0_ready got=%0b exp=1", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL add_req1_ready got=%0b exp=0", bus.req1_ready); end
    tick();
    bus.req0_valid = 0;
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL add_rsp_valid got=%0b exp=1", bus.rsp_valid); end
    checks++; if ({bus.rsp_port, bus.rsp_tag} !== {1'b0, 4'd3}) begin failures++; $display("FAIL add_port_tag got=%0b/%0d exp=0/3", bus.rsp_port, bus.rsp_tag); end
    checks++; if (bus.rsp_data !== 32'd12) begin failures++; $display("FAIL add_rsp_data got=%0d exp=12", bus.rsp_data); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL add_rsp_err got=%0b exp=0", bus.rsp_err); end
  endtask

  task automatic test_ops();
    bus.rsp_ready = 1;
    set_req(0, 1, 4'b0100, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'd5);
    tick();
    bus.req0_valid = 0;
    checks++; if (bus.rsp_data !== 32'h0F0F_F0F0) begin failures++; $display("FAIL xor_data got=%h exp=0f0ff0f0", bus.rsp_data); end
    set_req(1, 1, 4'b0001, 32'd0, 32'd1, 4'd6);
    tick();
    bus.req1_valid = 0;
    checks++; if (bus.rsp_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sub_wrap_data got=%h exp=ffffffff", bus.rsp_data); end
    checks++; if ({bus.rsp_port, bus.rsp_tag, bus.rsp_err} !== {1'b1, 4'd6, 1'b0}) begin failures++; $display("FAIL sub_fields got=%0b/%0d/%0b exp=1/6/0", bus.rsp_port, bus.rsp_tag, bus.rsp_err); end
  endtask

  task automatic test_illegal();
    bus.rsp_ready = 1;
    set_req(1, 1, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9);
    tick();
    bus.req1_valid = 0;
    checks++; if (bus.rsp_err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%0b exp=1", bus.rsp_err); end
    checks++; if (bus.rsp_data !== '0) begin failures++; $display("FAIL illegal_data got=%h exp=0", bus.rsp_data); end
    checks++; if ({bus.rsp_port, bus.rsp_tag} !== {1'b1, 4'd9}) begin failures++; $display("FAIL illegal_port_tag got=%0b/%0d exp=1/9", bus.rsp_port, bus.rsp_tag); end
    drain();
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 0, 1};
    bus.rsp_ready = 1;
    set_rand_req(0); set_rand_req(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({bus.req0_ready, bus.req1_ready} !== {order[i] == 0, order[i] == 1}) begin failures++; $display("FAIL rr_grant_%0d got=%b%b exp_port=%0d", i, bus.req0_ready, bus.req1_ready, order[i]); end
      tick();
      checks++; if ({bus.rsp_valid, bus.rsp_port} !== {1'b1, order[i] == 1}) begin failures++; $display("FAIL rr_rsp_%0d got=v%0b p%0b exp=v1 p%0d", i, bus.rsp_valid, bus.rsp_port, order[i]); end
      checks++; if ({bus.rsp_data, bus.rsp_err, bus.rsp_tag} !== {m_data, m_err, m_tag}) begin failures++; $display("FAIL rr_data_%0d got=%h/%0b/%0d exp=%h/%0b/%0d", i, bus.rsp_data, bus.rsp_err, bus.rsp_tag, m_data, m_err, m_tag); end
      set_rand_req(order[i]);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
`ifdef ALU_SHARE_PERF_EN
    checks++; if ({perf_grant0, perf_grant1, perf_conflict} !== {m_g0, m_g1, m_conf}) begin failures++; $display("FAIL rr_perf got=%0d/%0d/%0d exp=%0d/%0d/%0d", perf_grant0, perf_grant1, perf_conflict, m_g0, m_g1, m_conf); end
`endif
    drain();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 0;
    set_rand_req(0);
    tick();
    set_req(0, 1, 4'b0011, 32'hA5A5_0000, 32'h0000_5A5A, 4'd11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin failures++; $display("FAIL bp_ready_%0d got=%b%b exp=00", i, bus.req0_ready, bus.req1_ready); end
      checks++; if ({bus.rsp_valid, bus.rsp_port, bus.rsp_tag, bus.rsp_data, bus.rsp_err} !== {1'b1, m_port, m_tag, m_data, m_err}) begin failures++; $display("FAIL bp_hold_%0d got=%h/%0d exp=%h/%0d", i, bus.rsp_data, bus.rsp_tag, m_data, m_tag); end
      tick();
    end
    bus.rsp_ready = 1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", bus.req0_ready); end
    tick();
    bus.req0_valid = 0;
    checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag} !== {1'b1, 32'hA5A5_5A5A, 4'd11}) begin failures++; $display("FAIL bp_new_result got=v%0b %h/%0d exp=v1 a5a55a5a/11", bus.rsp_valid, bus.rsp_data, bus.rsp_tag); end
    drain();
  endtask

  task automatic test_random();
    int w;
    for (int c = 0; c < 400; c++) begin
      if (!bus.req0_valid && $urandom_range(0, 1) == 1) set_rand_req(0);
      if (!bus.req1_valid && $urandom_range(0, 1) == 1) set_rand_req(1);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      w = exp_winner();
      checks++; if ({bus.req0_ready, bus.req1_ready} !== {w == 0, w == 1}) begin failures++; $display("FAIL rnd_ready c=%0d got=%b%b exp_winner=%0d", c, bus.req0_ready, bus.req1_ready, w); end
      checks++; if ({bus.rsp_valid, bus.rsp_port, bus.rsp_tag, bus.rsp_data, bus.rsp_err} !== {m_full, m_port, m_tag, m_data, m_err}) begin failures++; $display("FAIL rnd_rsp c=%0d got=v%0b p%0b t%0d %h e%0b exp=v%0b p%0b t%0d %h e%0b", c, bus.rsp_valid, bus.rsp_port, bus.rsp_tag, bus.rsp_data, bus.rsp_err, m_full, m_port, m_tag, m_data, m_err); end
      tick();
      if (w == 0 && $urandom_range(0, 2) != 0) bus.req0_valid = 0;
      else if (w == 0) set_rand_req(0);
      if (w == 1 && $urandom_range(0, 2) != 0) bus.req1_valid = 0;
      else if (w == 1) set_rand_req(1);
    end
`ifdef ALU_SHARE_PERF_EN
    checks++; if ({perf_grant0, perf_grant1, perf_conflict} !== {m_g0, m_g1, m_conf}) begin failures++; $display("FAIL rnd_perf got=%0d/%0d/%0d exp=%0d/%0d/%0d", perf_grant0, perf_grant1, perf_conflict, m_g0, m_g1, m_conf); end
`endif
    drain();
  endtask

  task automatic test_reset_midop();
    bus.rsp_ready = 0;
    set_rand_req(0);
    tick();
    set_rand_req(0); set_rand_req(1);
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%0b exp=1", bus.rsp_valid); end
    #2;
    rst_n = 0;
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag} !== {1'b0, 32'd0, 4'd0}) begin failures++; $display("FAIL midrst_async got=v%0b %h/%0d exp=v0 0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_tag); end
    rst_n = 1;
    model_reset();
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL midrst_first_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
    tick();
    checks++; if ({bus.rsp_valid, bus.rsp_port, bus.rsp_data} !== {1'b1, 1'b0, m_data}) begin failures++; $display("FAIL midrst_result got=v%0b p%0b %h exp=v1 p0 %h", bus.rsp_valid, bus.rsp_port, bus.rsp_data, m_data); end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_ops();
    test_illegal();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
